regfile_mp: RTL and testbench

- Parametrised successor of the 2-read/1-write register file.
- Configurable width, depth and read-port count.
- Adds a per-register pending-write scoreboard for the pipeline's hazard/stall logic.
- Sits in the decode stage: read ports feed ID operands, the issue port marks destinations busy, and the WB stage drives the write port.

---
 rtl/regfile_mp_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its pending-write scoreboard.
package regfile_mp_pkg;
  localparam int REG_W     = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = 5;
  localparam int REG_NRD   = 2;
  localparam int R0        = 0;
  localparam int CNT_W     = REG_AW + 1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: busy vector, registered busy count and sticky issue error.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = REG_DEPTH,
  parameter int AW    = REG_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      busy_cnt,
  output logic             iss_err
);
  logic set, clr, same, inc, dec;

  always_comb begin
    set  = iss_en && (iss_addr != AW'(R0));
    clr  = clr_en && (clr_addr != AW'(R0));
    same = set && clr && (iss_addr == clr_addr);
    inc  = set && !busy[iss_addr];
    // a clear on the register being re-issued is overridden, so it cannot decrement
    dec  = clr && busy[clr_addr] && !same;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      iss_err  <= 1'b0;
    end else begin
      if (clr) busy[clr_addr] <= 1'b0;
      if (set) busy[iss_addr] <= 1'b1;
      if (inc && !dec)      busy_cnt <= busy_cnt + (AW+1)'(1);
      else if (dec && !inc) busy_cnt <= busy_cnt - (AW+1)'(1);
      if (set && busy[iss_addr] && !same) iss_err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read register file with pending-write scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int W     = REG_W,
  parameter int DEPTH = REG_DEPTH,
  parameter int AW    = REG_AW,
  parameter int NRD   = REG_NRD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [AW:0]       busy_cnt,
  output logic              iss_err
);
  if (AW != $clog2(DEPTH) || DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_aw
    $error("regfile_mp: AW must equal log2(DEPTH), DEPTH a power of two >= 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be 1..4");
  end

  logic [W-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= W'(i);
    end else if (wr_en && wr_addr != AW'(R0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clock    (clock),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt),
    .iss_err  (iss_err)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          b;
    assign a = rd_addr[k*AW +: AW];

    always_comb begin
      d = regs[a];
      b = busy[a];
      if (a == AW'(R0)) begin
        d = '0;
        b = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && wr_addr == a) begin
        // write-back lands this edge; only a same-cycle re-issue keeps it busy
        d = wr_data;
        b = iss_en && (iss_addr == a);
      end
`endif
    end

    assign rd_data[k*W +: W] = d;
    assign rd_busy[k]        = b;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Table-driven bench for regfile_mp with an expected-result queue; runs with or without REGFILE_BYPASS_EN.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [5:0]  busy_cnt;
  logic        iss_err;

  regfile_mp dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt), .iss_err(iss_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit we; logic [4:0] wa; logic [31:0] wd; bit ie; logic [4:0] ia;
    logic [4:0] r0; logic [4:0] r1; bit chk;
    logic [31:0] d0; logic [31:0] d1; bit b0; bit b1; logic [5:0] cnt; bit err;
  } vec_t;

  typedef struct {
    string tag; logic [31:0] d0; logic [31:0] d1; bit b0; bit b1; logic [5:0] cnt; bit err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t v(bit rst, bit we, int wa, logic [31:0] wd, bit ie, int ia,
                             int r0, int r1, bit chk, logic [31:0] d0, logic [31:0] d1,
                             bit b0, bit b1, int cnt, bit err);
    vec_t t;
    t.rst = rst; t.we = we; t.wa = 5'(wa); t.wd = wd; t.ie = ie; t.ia = 5'(ia);
    t.r0 = 5'(r0); t.r1 = 5'(r1); t.chk = chk;
    t.d0 = d0; t.d1 = d1; t.b0 = b0; t.b1 = b1; t.cnt = 6'(cnt); t.err = err;
    return t;
  endfunction

  task automatic cmp(string tag, string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %0h want %0h", tag, name, act, exp);
    end
  endtask

  // drive one cycle's inputs at negedge, sample combinational/registered outputs before posedge
  task automatic step(vec_t t, string tag);
    exp_t e;
    @(negedge clock);
    reset = t.rst; wr_en = t.we; wr_addr = t.wa; wr_data = t.wd;
    iss_en = t.ie; iss_addr = t.ia; rd_addr = {t.r1, t.r0};
    if (t.chk) begin
      e.tag = tag; e.d0 = t.d0; e.d1 = t.d1; e.b0 = t.b0; e.b1 = t.b1;
      e.cnt = t.cnt; e.err = t.err;
      sb.push_back(e);
    end
    #2;
    if (t.chk) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s.queue empty", tag);
      end else begin
        e = sb.pop_front();
        cmp(e.tag, "d0",  rd_data[31:0],  e.d0);
        cmp(e.tag, "d1",  rd_data[63:32], e.d1);
        cmp(e.tag, "b0",  32'(rd_busy[0]), 32'(e.b0));
        cmp(e.tag, "b1",  32'(rd_busy[1]), 32'(e.b1));
        cmp(e.tag, "cnt", 32'(busy_cnt),   32'(e.cnt));
        cmp(e.tag, "err", 32'(iss_err),    32'(e.err));
      end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

    //          rst we wa wd            ie ia r0 r1 chk d0                                d1                   b0       b1       cnt err
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 7, 0, 0, 0,                                0,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 7, 0, 1, 7,                                0,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          1, 5, 5, 0, 1, 5,                                0,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 5, 0, 1, 5,                                0,                   1,       0,       1,  0));
    tbl.push_back(v(1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1, BYP ? 32'hDEADBEEF : 32'd5,  0,                   !BYP,    0,       1,  0));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 5, 0, 1, 32'hDEADBEEF,                     0,                   0,       0,       0,  0));
    tbl.push_back(v(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 5, 1, 0,                              32'hDEADBEEF,        0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 0, 0, 1, 0,                                0,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          1, 3, 3, 4, 1, 3,                                4,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          1, 3, 3, 4, 1, 3,                                4,                   1,       0,       1,  0));
    tbl.push_back(v(1, 1, 4, 32'hAA,     1, 4, 3, 4, 1, 3,                                BYP ? 32'hAA : 32'd4, 1,      BYP,     1,  1));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 3, 4, 1, 3,                                32'hAA,              1,       1,       2,  1));
    tbl.push_back(v(1, 1, 9, 32'h1234,   0, 0, 9, 3, 1, BYP ? 32'h1234 : 32'd9,          3,                   0,       1,       2,  1));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 9, 4, 1, 32'h1234,                         32'hAA,              0,       1,       2,  1));
    tbl.push_back(v(1, 1, 3, 32'h77,     0, 0, 3, 9, 1, BYP ? 32'h77 : 32'd3,            32'h1234,            !BYP,    0,       2,  1));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 3, 4, 1, 32'h77,                           32'hAA,              0,       1,       1,  1));
    tbl.push_back(v(1, 0, 0, 0,          1, 1, 1, 2, 1, 1,                                2,                   0,       0,       1,  1));
    tbl.push_back(v(1, 0, 0, 0,          1, 2, 1, 2, 1, 1,                                2,                   1,       0,       2,  1));
    tbl.push_back(v(1, 0, 0, 0,          1, 3, 1, 2, 1, 1,                                2,                   1,       1,       3,  1));
    tbl.push_back(v(1, 0, 0, 0,          1, 5, 2, 3, 1, 2,                                32'h77,              1,       1,       4,  1));
    tbl.push_back(v(1, 1, 2, 32'h55,     1, 6, 5, 6, 1, 32'hDEADBEEF,                     6,                   1,       0,       5,  1));
    // reset asserted together with a write and issue to r7: reset must win
    tbl.push_back(v(0, 1, 7, 32'h99,     1, 7, 2, 6, 1, 32'h55,                           6,                   0,       1,       5,  1));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 2, 6, 1, 2,                                6,                   0,       0,       0,  0));
    tbl.push_back(v(1, 0, 0, 0,          0, 0, 7, 1, 1, 7,                                1,                   0,       0,       0,  0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // fill every register's busy bit, then drain via write-back
    for (int i = 1; i < 32; i++)
      step(v(1, 0, 0, 0, 1, i, i, 0, 1, 32'(i), 0, 0, 0, i - 1, 0), $sformatf("iss%0d", i));
    step(v(1, 0, 0, 0, 0, 0, 1, 31, 1, 1, 31, 1, 1, 31, 0), "full");
    for (int i = 1; i < 32; i++)
      step(v(1, 1, i, 32'hA000_0000 | 32'(i), 0, 0, i, 0, 1,
             BYP ? (32'hA000_0000 | 32'(i)) : 32'(i), 0, !BYP, 0, 32 - i, 0),
           $sformatf("wb%0d", i));
    step(v(1, 0, 0, 0, 0, 0, 31, 1, 1, 32'hA000_001F, 32'hA000_0001, 0, 0, 0, 0), "drained");

    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL queue.leftover got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
